// File: rtl/rx_byte_fifo_if.sv
// Handshake bundle for rx_byte_fifo: receiver/consumer side drives the
// master modport, the FIFO sits on the slave modport.
interface rx_byte_fifo_if #(
    parameter int AW = 3
);
    logic [7:0]  P_DATA;
    logic        data_valid;
    logic        frame_err;
    logic        rd_en;
    logic        flush;
    logic        clr_status;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic [AW:0] level;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic [7:0]  err_cnt;

    modport master (
        output P_DATA, data_valid, frame_err, rd_en, flush, clr_status,
        input  rd_data, rd_valid, empty, full, level, overflow, drop_cnt, err_cnt
    );

    modport slave (
        input  P_DATA, data_valid, frame_err, rd_en, flush, clr_status,
        output rd_data, rd_valid, empty, full, level, overflow, drop_cnt, err_cnt
    );
endinterface

// File: rtl/rx_byte_fifo.sv
// Receive byte FIFO behind a UART deserializer: stores bytes, registers reads,
// and keeps sticky overflow plus saturating drop / frame-error counters.
module rx_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic           CLK,
    input  logic           RST,
    rx_byte_fifo_if.slave  bus
);

    logic [7:0]    mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AW:0]   level_q,    level_d;
    logic          empty_q,    empty_d;
    logic          full_q,     full_d;
    logic [7:0]    rd_data_q,  rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic [7:0]    err_cnt_q,  err_cnt_d;

    logic          rd_accept_s;
    logic          wr_accept_s;
    logic          mem_we_s;
    logic          drop_s;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    // Next-state logic for pointers, occupancy, read port and status counters.
    always_comb begin
        rd_accept_s = bus.rd_en && !empty_q;
        wr_accept_s = bus.data_valid && (!full_q || rd_accept_s);
        // A write landing in a flush cycle is discarded, not counted as a drop.
        drop_s      = bus.data_valid && full_q && !rd_accept_s && !bus.flush;
        mem_we_s    = wr_accept_s && !bus.flush;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_accept_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_accept_s) begin
                rd_ptr_d   = rd_ptr_q + AW'(1);
                rd_data_d  = mem_q[rd_ptr_q];
                rd_valid_d = 1'b1;
            end else begin
                rd_ptr_d   = rd_ptr_q;
            end
            case ({wr_accept_s, rd_accept_s})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end

        empty_d = (level_d == (AW+1)'(0));
        full_d  = (level_d == (AW+1)'(DEPTH));

        // Same-cycle events win over clr_status so they are never lost.
        if (drop_s) begin
            overflow_d = 1'b1;
            drop_cnt_d = bus.clr_status ? 8'd1 : sat_inc(drop_cnt_q);
        end else if (bus.clr_status) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end else begin
            overflow_d = overflow_q;
            drop_cnt_d = drop_cnt_q;
        end

        if (bus.frame_err) begin
            err_cnt_d = bus.clr_status ? 8'd1 : sat_inc(err_cnt_q);
        end else if (bus.clr_status) begin
            err_cnt_d = 8'd0;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
            err_cnt_q  <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Byte storage; contents are don't-care until written, so no reset.
    always_ff @(posedge CLK) begin
        if (RST && mem_we_s) begin
            mem_q[wr_ptr_q] <= bus.P_DATA;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;
    assign bus.drop_cnt = drop_cnt_q;
    assign bus.err_cnt  = err_cnt_q;

endmodule

// File: doc/rx_byte_fifo.md
RX_BYTE_FIFO -- requirements
Module: rx_byte_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of byte entries (power of two, 2..64).
REQ-002 SHALL have parameter AW, default 3, pointer width = log2(DEPTH).
REQ-003 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port P_DATA  input  8  deserialized byte from the receiver.
REQ-006 SHALL have port data_valid  input  1  one-cycle pulse; P_DATA is valid in that cycle.
REQ-007 SHALL have port frame_err  input  1  one-cycle pulse per frame rejected for parity or stop error.
REQ-008 SHALL have port rd_en  input  1  consumer read request.
REQ-009 SHALL have port flush  input  1  discard all stored bytes.
REQ-010 SHALL have port clr_status  input  1  clear sticky flag and counters.
REQ-011 SHALL have port rd_data  output  8  registered read byte.
REQ-012 SHALL have port rd_valid  output  1  rd_data valid, one-cycle pulse.
REQ-013 SHALL have port empty  output  1  no bytes stored.
REQ-014 SHALL have port full  output  1  DEPTH bytes stored.
REQ-015 SHALL have port level  output  AW+1  number of bytes stored, 0..DEPTH.
REQ-016 SHALL have port overflow  output  1  sticky; a byte was dropped.
REQ-017 SHALL have port drop_cnt  output  8  dropped bytes, saturating.
REQ-018 SHALL have port err_cnt  output  8  frame_err pulses, saturating.

Function
REQ-019 Write SHALL occur when data_valid=1 and (full=0 or an accepted read occurs in the same cycle); P_DATA goes to mem[wr_ptr], wr_ptr increments modulo DEPTH.
REQ-020 Accepted read SHALL occur when rd_en=1 and empty=0; mem[rd_ptr] is registered into rd_data, rd_valid=1 on the next cycle, rd_ptr increments modulo DEPTH.
REQ-021 rd_en while empty=1 SHALL be ignored: rd_valid stays 0, rd_data holds its value, pointers unchanged.
REQ-022 rd_valid SHALL be 0 in every cycle that does not follow an accepted read; rd_data holds its last value.
REQ-023 level SHALL update the cycle after the event: +1 on write only, -1 on accepted read only, unchanged on both or neither.
REQ-024 empty SHALL equal (level==0) and full SHALL equal (level==DEPTH), both registered with level.
REQ-025 Simultaneous write and accepted read while full SHALL both complete; level stays DEPTH; no drop.
REQ-026 Simultaneous write and read while empty SHALL write only (read ignored per REQ-021); level becomes 1.
REQ-027 data_valid while full without accepted read SHALL drop the byte, set overflow=1, and increment drop_cnt unless it equals 255.
REQ-028 frame_err=1 SHALL increment err_cnt unless it equals 255; no data stored.
REQ-029 Pointer wrap SHALL be seamless: byte order preserved across wr_ptr/rd_ptr wrap.
REQ-030 flush=1 SHALL set wr_ptr=rd_ptr=0 and level=0 next cycle; any write or read that cycle is discarded; rd_valid=0 next cycle; overflow and counters unaffected.
REQ-031 clr_status=1 SHALL clear overflow, drop_cnt, err_cnt next cycle; a drop or frame_err in the same cycle SHALL take priority and be counted (counter=1, overflow=1).
REQ-032 Memory contents SHALL NOT require reset; only pointers, level, flags, counters, rd_data, rd_valid.

Reset
REQ-033 On rising CLK with RST=0: wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, rd_data=8'h00, rd_valid=0, overflow=0, drop_cnt=0, err_cnt=0.
REQ-034 Reset SHALL dominate all inputs including flush, clr_status, data_valid; asserted mid-operation it discards stored bytes.
REQ-035 With RST=1 deasserted, first write SHALL be accepted on the first following clock edge.

Verification
REQ-036 Write 8'hA5, 8'h3C, then rd_en twice -> rd_valid pulses with rd_data A5 then 3C; empty=1, level=0 after.
REQ-037 Write 8 bytes 00..07, then 9th byte 08 -> full=1, overflow=1, drop_cnt=1; reading 8 returns 00..07 only.
REQ-038 Full, assert data_valid(8'hFF) and rd_en same cycle -> level stays 8, no overflow, FF read last.
REQ-039 Write/read 20 bytes interleaved across pointer wrap -> output order equals input order, level never exceeds 8.
REQ-040 300 frame_err pulses -> err_cnt=255; clr_status -> 0; clr_status with simultaneous frame_err -> err_cnt=1.
REQ-041 Store 5 bytes, flush -> level=0, empty=1, rd_en gives no rd_valid; store 3, RST=0 one cycle -> all outputs at REQ-033 values.
